// File: rtl/alarm_controller_if.sv
// Bundle of time, alarm-setting, control and status signals shared between
// the alarm controller and whatever drives it.
interface alarm_controller_if #(
  parameter int NUM_ALARMS = 3
);
  logic                      tick_1hz;
  logic [5:0]                hour_decimal;
  logic [5:0]                minute_decimal;
  logic [5:0]                second_decimal;
  logic [6*NUM_ALARMS-1:0]   alarm_hour;
  logic [6*NUM_ALARMS-1:0]   alarm_minute;
  logic [6*NUM_ALARMS-1:0]   alarm_second;
  logic [NUM_ALARMS-1:0]     alarm_arm;
  logic                      ack;
  logic                      snooze;
  logic [NUM_ALARMS-1:0]     alarm_en;
  logic [NUM_ALARMS-1:0]     alarm_snoozing;
  logic                      any_ring;

  // Time source / user side: drives time, settings and buttons, observes status.
  modport master (
    output tick_1hz, hour_decimal, minute_decimal, second_decimal,
    output alarm_hour, alarm_minute, alarm_second, alarm_arm, ack, snooze,
    input  alarm_en, alarm_snoozing, any_ring
  );

  // Controller side.
  modport slave (
    input  tick_1hz, hour_decimal, minute_decimal, second_decimal,
    input  alarm_hour, alarm_minute, alarm_second, alarm_arm, ack, snooze,
    output alarm_en, alarm_snoozing, any_ring
  );
endinterface

// File: rtl/alarm_controller.sv
// Multi-channel alarm clock controller. Each channel watches for its alarm
// time, rings for RING_SECS ticks, and can be snoozed up to MAX_SNOOZE times
// for SNOOZE_SECS ticks each. ack / snooze act on all channels at once.
// rst_n is an active-high synchronous reset despite its name.
module alarm_controller #(
  parameter int NUM_ALARMS  = 3,
  parameter int RING_SECS   = 10,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  alarm_controller_if.slave bus
);

  localparam int RING_W = $clog2(RING_SECS + 1);
  localparam int SNZ_W  = $clog2(SNOOZE_SECS + 1);
  localparam int CNT_W  = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  localparam logic [RING_W-1:0] RING_LOAD = RING_W'(RING_SECS);
  localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SECS);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  logic [NUM_ALARMS-1:0] en_n;
  logic [NUM_ALARMS-1:0] snz_n;
  logic                  post_rst;

  // Low for the first cycle after reset so a match already present at release
  // only loads match_q and cannot look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst_n) post_rst <= 1'b0;
    else       post_rst <= 1'b1;
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
    state_t            state, state_n;
    logic [RING_W-1:0] ring_cnt, ring_cnt_n;
    logic [SNZ_W-1:0]  snz_cnt, snz_cnt_n;
    logic [CNT_W-1:0]  snz_num, snz_num_n;
    logic              match, match_q, trigger;

    assign match   = bus.alarm_arm[i]
                   && (bus.hour_decimal   == bus.alarm_hour[6*i +: 6])
                   && (bus.minute_decimal == bus.alarm_minute[6*i +: 6])
                   && (bus.second_decimal == bus.alarm_second[6*i +: 6]);
    assign trigger = match && !match_q && post_rst;

    // Channel state, counters and match history.
    always_ff @(posedge clk) begin
      if (rst_n) begin
        state    <= IDLE;
        ring_cnt <= '0;
        snz_cnt  <= '0;
        snz_num  <= '0;
        match_q  <= 1'b0;
      end else begin
        state    <= state_n;
        ring_cnt <= ring_cnt_n;
        snz_cnt  <= snz_cnt_n;
        snz_num  <= snz_num_n;
        match_q  <= match;
      end
    end

    // Next state: ack beats snooze, either beats a coincident tick; disarm beats all.
    always_comb begin
      state_n    = state;
      ring_cnt_n = ring_cnt;
      snz_cnt_n  = snz_cnt;
      snz_num_n  = snz_num;
      if (!bus.alarm_arm[i]) begin
        state_n    = IDLE;
        ring_cnt_n = '0;
        snz_cnt_n  = '0;
        snz_num_n  = '0;
      end else begin
        case (state)
          IDLE: begin
            if (trigger) begin
              state_n    = RING;
              ring_cnt_n = RING_LOAD;
            end
          end
          RING: begin
            if (bus.ack || (bus.snooze && (snz_num >= CNT_MAX))) begin
              state_n    = IDLE;
              ring_cnt_n = '0;
              snz_num_n  = '0;
            end else if (bus.snooze) begin
              state_n    = SNOOZE;
              ring_cnt_n = '0;
              snz_cnt_n  = SNZ_LOAD;
              snz_num_n  = snz_num + CNT_W'(1);
            end else if (bus.tick_1hz) begin
              if (ring_cnt <= RING_W'(1)) begin
                state_n    = IDLE;
                ring_cnt_n = '0;
                snz_num_n  = '0;
              end else begin
                ring_cnt_n = ring_cnt - RING_W'(1);
              end
            end
          end
          SNOOZE: begin
            if (bus.ack) begin
              state_n   = IDLE;
              snz_cnt_n = '0;
              snz_num_n = '0;
            end else if (bus.tick_1hz) begin
              if (snz_cnt <= SNZ_W'(1)) begin
                state_n    = RING;
                snz_cnt_n  = '0;
                ring_cnt_n = RING_LOAD;
              end else begin
                snz_cnt_n = snz_cnt - SNZ_W'(1);
              end
            end
          end
          default: begin
            state_n    = IDLE;
            ring_cnt_n = '0;
            snz_cnt_n  = '0;
            snz_num_n  = '0;
          end
        endcase
      end
    end

    assign en_n[i]  = (state_n == RING);
    assign snz_n[i] = (state_n == SNOOZE);
  end

  // Registered status outputs, aligned with the channel state registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      bus.alarm_en       <= '0;
      bus.alarm_snoozing <= '0;
      bus.any_ring       <= 1'b0;
    end else begin
      bus.alarm_en       <= en_n;
      bus.alarm_snoozing <= snz_n;
      bus.any_ring       <= |en_n;
    end
  end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 The block SHALL have parameter NUM_ALARMS, default 3, number of alarm channels (legal 1..8).
REQ-002 The block SHALL have parameter RING_SECS, default 10, ring duration in tick_1hz pulses (legal 1..59).
REQ-003 The block SHALL have parameter SNOOZE_SECS, default 300, snooze duration in tick_1hz pulses (legal 1..3599).
REQ-004 The block SHALL have parameter MAX_SNOOZE, default 3, snoozes allowed per trigger (legal 0..7).
REQ-005 The block SHALL have port clk, input, 1, system clock; one clock, all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-007 The block SHALL have port tick_1hz, input, 1, one-cycle pulse per second of wall time.
REQ-008 The block SHALL have ports hour_decimal, minute_decimal and second_decimal, input, 6 each, current time (0-23, 0-59, 0-59).
REQ-009 The block SHALL have ports alarm_hour, alarm_minute and alarm_second, input, 6*NUM_ALARMS each, packed per-channel settings (channel i at bits [6i+5:6i]).
REQ-010 The block SHALL have port alarm_arm, input, NUM_ALARMS, per-channel enable; 00:00:00 SHALL be a valid alarm time.
REQ-011 The block SHALL have port ack, input, 1, one-cycle pulse that stops all ringing and snoozing channels.
REQ-012 The block SHALL have port snooze, input, 1, one-cycle pulse that snoozes all ringing channels.
REQ-013 The block SHALL have port alarm_en, output, NUM_ALARMS, per-channel ringing flag, registered.
REQ-014 The block SHALL have port alarm_snoozing, output, NUM_ALARMS, per-channel snooze flag, registered.
REQ-015 The block SHALL have port any_ring, output, 1, OR of alarm_en, registered in the same cycle as alarm_en.

Function
REQ-016 Each channel SHALL run an independent FSM with states IDLE, RING and SNOOZE; alarm_en=1 only in RING, alarm_snoozing=1 only in SNOOZE.
REQ-017 Per channel, match SHALL be alarm_arm[i] AND exact equality of all three time fields; match_q SHALL be match registered each cycle.
REQ-018 Trigger SHALL be match AND NOT match_q (rising edge); IDLE->RING on trigger, with alarm_en high the cycle after the time inputs first match.
REQ-019 On entry to RING, the ring counter SHALL load RING_SECS and decrement on each tick_1hz; on the tick that makes it 0 -> IDLE (timeout), snooze count cleared.
REQ-020 RING with ack -> IDLE, snooze count cleared.
REQ-021 RING with snooze and snooze count < MAX_SNOOZE -> SNOOZE, snooze count +1, snooze counter loaded with SNOOZE_SECS.
REQ-022 RING with snooze and snooze count == MAX_SNOOZE SHALL be treated as ack.
REQ-023 SNOOZE SHALL decrement the snooze counter on each tick_1hz; on the tick that reaches 0 -> RING with the ring counter reloaded, snooze count retained.
REQ-024 SNOOZE with ack -> IDLE, snooze count cleared; snooze pulses in SNOOZE and IDLE SHALL be ignored.
REQ-025 ack and snooze asserted in the same cycle: ack SHALL win.
REQ-026 tick_1hz coincident with ack or snooze: ack or snooze SHALL win, with no counter decrement.
REQ-027 alarm_arm[i] low in any state -> IDLE next cycle, counters and snooze count cleared.
REQ-028 Triggers in RING or SNOOZE SHALL be ignored; a channel acked within its matching second SHALL NOT retrigger, because match_q is still high.
REQ-029 Settings changes SHALL take effect only through match; they SHALL NOT alter an in-progress ring or snooze.
REQ-030 Counter widths SHALL be sized by $clog2 of the parameter value; no wrap-around SHALL occur because counters stop at 0.
REQ-031 Multiple channels SHALL ring concurrently and independently; ack and snooze SHALL apply to every channel in a qualifying state in the same cycle.

Reset
REQ-032 While rst_n=1, alarm_en, alarm_snoozing and any_ring SHALL be 0; all FSMs SHALL be IDLE; counters, snooze counts and match_q SHALL be 0.
REQ-033 Reset asserted mid-ring or mid-snooze SHALL abort it; after release, a still-present match SHALL NOT trigger until match drops and rises again, because match_q is held at 0 during reset and loads from the first post-reset cycle.

Verification
REQ-034 Default parameters, ch0 set to 07:30:00 and armed, time steps 07:29:59->07:30:00 -> alarm_en[0]=1 one cycle later; it SHALL stay high for exactly 10 ticks, then return to 0.
REQ-035 Ringing ch0 with a snooze pulse -> alarm_snoozing[0]=1, alarm_en[0]=0; after 300 ticks alarm_en[0]=1 again; after the 4th snooze pulse, ch0 SHALL go IDLE.
REQ-036 ch0 and ch2 both set to 12:00:00, ack at tick 3 -> both alarm_en bits fall the next cycle; no retrigger while time = 12:00:00.
REQ-037 ch1 set to 00:00:00 and armed, time wraps 23:59:59->00:00:00 -> alarm_en[1]=1.
REQ-038 ack and snooze in the same cycle while ringing -> IDLE, snooze count 0; alarm_arm[0] dropped during SNOOZE -> IDLE next cycle.
REQ-039 rst_n pulsed during RING -> all outputs 0 next cycle; no retrigger while time still equals the alarm time.
